// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the sprite DMA block: the DMA controller state type
// and the two CPU-visible register addresses it cares about.
//   OAMDMA_ADDR  : CPU write here (data = source page) starts a sprite DMA.
//   OAMDATA_ADDR : PPU sprite-memory data port the DMA writes every byte to.
// -----------------------------------------------------------------------------
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_dma_ctrl
// Sprite (OAM) DMA controller. A CPU write to $4014 halts the CPU and copies
// the 256 bytes of page {page,8'h00}..{page,8'hFF} to $2004, one read and one
// write per CPU cycle, after a one-cycle halt (plus one alignment cycle when
// odd-cycle alignment is built in and the cycle parity is odd at halt exit).
//
// Build option:
//   SPRITE_DMA_ODD_ALIGN_EN - when defined, HALT goes to ALIGN if the cycle
//   parity bit is 1 at the HALT-exit strobe (514-cycle transfer). When not
//   defined ALIGN is unreachable and every transfer is 513 cycles.
//
// Ports:
//   clk_in          system clock, all registers on rising edge
//   rst_in          synchronous active-high reset
//   ce_in           one-clk CPU-cycle strobe; state only advances when 1
//   cpu_a_in        CPU address bus
//   cpu_d_in        CPU write data
//   cpu_r_nw_in     CPU read/not-write
//   mem_d_in        bus read data, valid on the strobe of a DMA read cycle
//   rdy_out         CPU ready (0 halts the CPU)
//   dma_active_out  DMA owns the bus (READ and WRITE only)
//   dma_a_out       DMA bus address
//   dma_d_out       DMA write data (buffered byte in WRITE, else 0)
//   dma_r_nw_out    DMA read/not-write (0 only in WRITE)
//   state_dbg_out   current controller state, for observation only
//
// Handshake: the CPU bus transfer happens on a clk where ce_in=1. The DMA
// bus outputs are a pure function of the registered state, so they are
// stable for the whole CPU cycle leading up to that strobe; mem_d_in is
// captured on the strobe of a READ cycle. rdy_out=0 tells the CPU to stall
// until the controller is back in IDLE.
// -----------------------------------------------------------------------------
module sprite_dma_ctrl
  import nes_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ce_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  mem_d_in,
  output logic        rdy_out,
  output logic        dma_active_out,
  output logic [15:0] dma_a_out,
  output logic [7:0]  dma_d_out,
  output logic        dma_r_nw_out,
  output dma_state_e  state_dbg_out
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] buffer_q, buffer_d;
  logic       parity_q, parity_d;

  // Next-state logic. Everything holds unless ce_in is high.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    parity_d = parity_q;
    if (ce_in) begin
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          // Only a write starts a transfer; $4014 writes in other states
          // fall through untouched.
          if (!cpu_r_nw_in && (cpu_a_in == OAMDMA_ADDR)) begin
            page_d  = cpu_d_in;
            index_d = 8'h00;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
`ifdef SPRITE_DMA_ODD_ALIGN_EN
          state_d = parity_q ? ST_ALIGN : ST_READ;
`else
          state_d = ST_READ;
`endif
        end
        ST_ALIGN: state_d = ST_READ;
        ST_READ: begin
          buffer_d = mem_d_in;
          state_d  = ST_WRITE;
        end
        ST_WRITE: begin
          // 8-bit wrap is intentional: the page never changes, so $xxFF is
          // the last byte and the transfer ends there.
          index_d = index_q + 8'd1;
          state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only.
  always_comb begin
    rdy_out        = 1'b0;
    dma_active_out = 1'b0;
    dma_a_out      = 16'h0000;
    dma_d_out      = 8'h00;
    dma_r_nw_out   = 1'b1;
    case (state_q)
      ST_IDLE: rdy_out = 1'b1;
      ST_READ: begin
        dma_active_out = 1'b1;
        dma_a_out      = {page_q, index_q};
      end
      ST_WRITE: begin
        dma_active_out = 1'b1;
        dma_a_out      = OAMDATA_ADDR;
        dma_d_out      = buffer_q;
        dma_r_nw_out   = 1'b0;
      end
      default: ;
    endcase
  end

  assign state_dbg_out = state_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      buffer_q <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_dma_ctrl
// Self-checking bench for sprite_dma_ctrl. The reference model describes a
// transfer as a list of CPU cycles (halt, optional align, then 256 read/write
// pairs) computed from the page number, the bench's own memory image and the
// bench's own count of CPU strobes since reset.
// -----------------------------------------------------------------------------
module tb_sprite_dma_ctrl;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rnw;
  logic [7:0]  mem_d;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_rnw;
  dma_state_e  state_dbg;

  logic [7:0] mem [0:65535];
  assign mem_d = mem[dma_a];

  always #5 clk = ~clk;

  sprite_dma_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ce_in          (ce),
    .cpu_a_in       (cpu_a),
    .cpu_d_in       (cpu_d),
    .cpu_r_nw_in    (cpu_rnw),
    .mem_d_in       (mem_d),
    .rdy_out        (rdy),
    .dma_active_out (dma_active),
    .dma_a_out      (dma_a),
    .dma_d_out      (dma_d),
    .dma_r_nw_out   (dma_rnw),
    .state_dbg_out  (state_dbg)
  );

  typedef struct packed {
    logic        rdy;
    logic        act;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;
    dma_state_e  st;
  } obs_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rnw;
    obs_t        exp_after;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   ce_count = 0;
  logic last_rdy;

  localparam int NONE = 9999;

  function automatic obs_t mk(logic r, logic act, logic [15:0] a, logic rnw,
                              logic [7:0] d, dma_state_e st);
    obs_t o;
    o.rdy = r; o.act = act; o.a = a; o.rnw = rnw; o.d = d; o.st = st;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, ST_IDLE);
  endfunction

  // Expected bus view of CPU cycle k of a transfer from 'page'.
  function automatic obs_t exp_cycle(logic [7:0] page, bit align, int k);
    int h, j;
    logic [7:0]  idx;
    logic [15:0] addr;
    h = align ? 2 : 1;
    if (k == 0) return mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, ST_HALT);
    if (align && k == 1) return mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, ST_ALIGN);
    j    = k - h;
    idx  = 8'(j / 2);
    addr = {page, idx};
    if (j % 2 == 0) return mk(1'b0, 1'b1, addr, 1'b1, 8'h00, ST_READ);
    return mk(1'b0, 1'b1, OAMDATA_ADDR, 1'b0, mem[addr], ST_WRITE);
  endfunction

  task automatic check_obs(input string tag, input int idx, input obs_t e);
    obs_t g;
    g = mk(rdy, dma_active, dma_a, dma_rnw, dma_d, state_dbg);
    last_rdy = rdy;
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s[%0d]: got rdy=%0b act=%0b a=%h rnw=%0b d=%h st=%0d want rdy=%0b act=%0b a=%h rnw=%0b d=%h st=%0d",
               tag, idx, g.rdy, g.act, g.a, g.rnw, g.d, g.st,
               e.rdy, e.act, e.a, e.rnw, e.d, e.st);
    end
  endtask

  // One CPU cycle: two clocks without strobe, then a strobe clock carrying
  // the given CPU bus values. Outputs are checked just before the strobe edge.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic rnw, input obs_t e, input string tag,
                           input int idx);
    @(negedge clk); ce = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rnw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); ce = 1'b1; cpu_a = a; cpu_d = d; cpu_rnw = rnw;
    check_obs(tag, idx, e);
    @(posedge clk);
    ce_count++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      cpu_cycle(16'h0000, 8'h00, 1'b1, idle_obs(), "idle", i);
  endtask

  // Full transfer with optional disturbances, offsets counted from the first
  // READ cycle: a second $4014 write, a 10-clk strobe stall, or a reset.
  task automatic run_transfer(input logic [7:0] page, input int inj_j,
                              input int stall_j, input int abort_j);
    bit   align;
    int   h, total, low;
    obs_t e;
    cpu_cycle(OAMDMA_ADDR, page, 1'b0, idle_obs(), "trigger", 0);
`ifdef SPRITE_DMA_ODD_ALIGN_EN
    align = (ce_count % 2) == 1;
`else
    align = 1'b0;
`endif
    h = align ? 2 : 1;
    total = h + 512;
    low = 0;
    for (int k = 0; k < total; k++) begin
      e = exp_cycle(page, align, k);
      if (k == h + stall_j) begin
        repeat (10) begin
          @(negedge clk); ce = 1'b0;
          check_obs("stall_hold", k, e);
          @(posedge clk);
        end
      end
      if (k == h + abort_j) begin
        @(negedge clk); ce = 1'b0;
        check_obs("pre_abort", k, e);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        ce_count = 0;
        check_obs("abort_idle", k, idle_obs());
        return;
      end
      if (k == h + inj_j)
        cpu_cycle(OAMDMA_ADDR, page ^ 8'h5A, 1'b0, e, "xfer_inj", k);
      else
        cpu_cycle(16'h0000, 8'h00, 1'b1, e, "xfer", k);
      if (last_rdy == 1'b0) low++;
    end
    cpu_cycle(16'h0000, 8'h00, 1'b1, idle_obs(), "post_idle", total);
    checks++;
    if (low != total) begin
      failures++;
      $display("FAIL halt_len: got %0d want %0d", low, total);
    end
  endtask

  vec_t vecs [6];

  initial begin
    rst = 1'b1; ce = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rnw = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));

    // Non-trigger CPU accesses in IDLE; the cycle after each must be IDLE.
    vecs[0] = '{16'h4014, 8'h02, 1'b1, idle_obs()};
    vecs[1] = '{16'h4015, 8'h02, 1'b0, idle_obs()};
    vecs[2] = '{16'h2004, 8'h33, 1'b0, idle_obs()};
    vecs[3] = '{16'h4013, 8'hFF, 1'b0, idle_obs()};
    vecs[4] = '{16'h0014, 8'h02, 1'b0, idle_obs()};
    vecs[5] = '{16'hC014, 8'h07, 1'b0, idle_obs()};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("reset_state", 0, idle_obs());
    rst = 1'b0;
    ce_count = 0;

    cpu_cycle(vecs[0].a, vecs[0].d, vecs[0].rnw, idle_obs(), "vec_apply", 0);
    for (int i = 1; i < 6; i++)
      cpu_cycle(vecs[i].a, vecs[i].d, vecs[i].rnw, vecs[i-1].exp_after, "vec_after", i - 1);
    cpu_cycle(16'h0000, 8'h00, 1'b1, vecs[5].exp_after, "vec_after", 5);

    // Basic transfer from page $02 triggered at parity 0.
    if (ce_count % 2 == 1) idle_cycles(1);
    run_transfer(8'h02, NONE, NONE, NONE);

    // Top page: reads $FF00-$FFFF, data = low address byte.
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i);
    run_transfer(8'hFF, NONE, NONE, NONE);

    // Both parities at the trigger (covers align / no-align when built in).
    if (ce_count % 2 == 0) idle_cycles(1);
    run_transfer(8'h11, NONE, NONE, NONE);
    if (ce_count % 2 == 1) idle_cycles(1);
    run_transfer(8'h12, NONE, NONE, NONE);

    // Second $4014 write mid-transfer must be ignored.
    run_transfer(8'h03, 51, NONE, NONE);

    // Strobe held low for 10 clks during a READ.
    run_transfer(8'h04, NONE, 40, NONE);

    // Reset during the WRITE of index $40, then a clean restart.
    run_transfer(8'h05, NONE, NONE, 2 * 8'h40 + 1);
    idle_cycles(1);
    run_transfer(8'h05, NONE, NONE, NONE);

    // Randomized pages and idle gaps.
    for (int t = 0; t < 4; t++) begin
      idle_cycles($urandom_range(0, 3));
      run_transfer(8'($urandom_range(0, 255)), NONE, NONE, NONE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_dma_ctrl.md
SPRITE_DMA_CTRL -- requirements
Module: sprite_dma_ctrl

Interface
REQ-001 SHALL have clk_in, input, 1, system clock (25 MHz domain); every register is clocked on its rising edge.
REQ-002 SHALL have rst_in, input, 1, synchronous active-high reset.
REQ-003 SHALL have ce_in, input, 1, single-clk CPU-cycle strobe; all state advances only when ce_in=1.
REQ-004 SHALL have cpu_a_in, input, 16, CPU address bus.
REQ-005 SHALL have cpu_d_in, input, 8, CPU write data bus.
REQ-006 SHALL have cpu_r_nw_in, input, 1, CPU read/not-write.
REQ-007 SHALL have mem_d_in, input, 8, read data returned by the shared bus, valid on the ce_in of a DMA read cycle.
REQ-008 SHALL have rdy_out, output, 1, CPU ready; 0 halts the CPU.
REQ-009 SHALL have dma_active_out, output, 1, DMA owns the CPU bus; top-level muxes address, data and r_nw onto the bus when set.
REQ-010 SHALL have dma_a_out, output, 16, DMA bus address.
REQ-011 SHALL have dma_d_out, output, 8, DMA write data.
REQ-012 SHALL have dma_r_nw_out, output, 1, DMA read/not-write.

Function
REQ-013 SHALL detect a trigger when ce_in=1, cpu_r_nw_in=0 and cpu_a_in=16'h4014 in state IDLE; page register <= cpu_d_in, index <= 0, state <= HALT.
REQ-014 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE; transitions occur only on a ce_in=1 clock.
REQ-015 SHALL drive rdy_out=0 in every state except IDLE, starting the clk after the trigger.
REQ-016 HALT SHALL last one CPU cycle, then go to ALIGN if alignment is required (REQ-026), else READ.
REQ-017 ALIGN SHALL last one CPU cycle, then go to READ.
REQ-018 READ SHALL drive dma_a_out={page,index}, dma_r_nw_out=1; on ce_in, buffer <= mem_d_in, state <= WRITE.
REQ-019 WRITE SHALL drive dma_a_out=16'h2004, dma_d_out=buffer, dma_r_nw_out=0; on ce_in, index <= index+1 (8-bit) and state <= READ, or IDLE if index was 8'hFF.
REQ-020 dma_active_out SHALL be 1 exactly in READ and WRITE; in IDLE/HALT/ALIGN, dma_r_nw_out=1.
REQ-021 Total halt length SHALL be 513 CPU cycles (514 with alignment); exactly 256 reads and 256 writes, addresses {page,8'h00}..{page,8'hFF} in order.
REQ-022 Writes to $4014 while not IDLE SHALL be ignored; page 8'hFF SHALL read $FF00-$FFFF without wrap into page 0.
REQ-023 ce_in=0 SHALL hold all state, outputs and counters unchanged.
REQ-024 A cycle-parity bit SHALL toggle on every ce_in=1 regardless of state.

Reset
REQ-025 rst_in (sampled on the clk edge, including mid-transfer) SHALL set state=IDLE, rdy_out=1, dma_active_out=0, dma_r_nw_out=1, dma_a_out=0, dma_d_out=0, page=0, index=0, buffer=0, parity=0; an aborted transfer is not resumed.

Configuration
REQ-026 With SPRITE_DMA_ODD_ALIGN_EN defined, HALT SHALL go to ALIGN when parity=1 at the HALT-exit ce_in; without it, ALIGN is unreachable and every transfer is 513 cycles.

Structure
REQ-027 Shared package nes_pkg SHALL hold the state enum type, OAMDMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004.
REQ-028 SHALL be a single flat module; no sub-module.

Verification
REQ-029 ce_in every 3 clks, write 8'h02 to $4014 at parity 0 -> rdy_out low 513 CPU cycles; reads $0200..$02FF each followed by a write to $2004 of the read byte.
REQ-030 SPRITE_DMA_ODD_ALIGN_EN defined, trigger with parity=1 at HALT exit -> 514 cycles, one ALIGN cycle with dma_active_out=0; macro undefined -> 513.
REQ-031 page 8'hFF, mem_d_in = low address byte -> last read at $FFFF, 256th write data 8'hFF, then IDLE with rdy_out=1.
REQ-032 assert rst_in during WRITE at index 8'h40 -> next clk state IDLE, rdy_out=1, dma_active_out=0; subsequent trigger restarts at index 0.
REQ-033 second write to $4014 during transfer, and a CPU read of $4014 in IDLE -> neither changes page nor starts a transfer.
REQ-034 ce_in held low 10 clks mid-READ -> dma_a_out, state and index unchanged; transfer completes with correct count.
